alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Command sequencer that sits directly upstream of the 4-bit combinational ALU. It drives the ALU's `a`, `b` and `alu_ch` inputs, and captures `alu_f`, `zero_f`, `over_f` and `cout_f` one cycle later.
- Buffers incoming operations in a small FIFO and issues them one at a time, in order.
- Returns each registered result with its flags over a valid/ready handshake. Also keeps an accumulator and an operation counter.

Parameters:
- DEPTH, 4: command FIFO entries; power of two, at least 2.
- CNT_W, 8: width of the completed-operation counter.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  FIFO can accept; equals !full
- cmd_op  input  3  opcode, passed unmodified to the ALU's alu_ch
- cmd_a  input  4  operand a
- cmd_b  input  4  operand b
- cmd_acc  input  1  use the accumulator as operand a (see Optional Feature)
- alu_a  output  4  registered operand a to the ALU
- alu_b  output  4  registered operand b to the ALU
- alu_ch  output  3  registered opcode to the ALU
- alu_f  input  4  ALU result (combinational)
- zero_f  input  1  ALU zero flag
- over_f  input  1  ALU overflow flag
- cout_f  input  1  ALU carry-out flag
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts the result
- res_data  output  4  captured result
- res_zero  output  1  captured zero flag
- res_over  output  1  captured overflow flag
- res_cout  output  1  captured carry-out flag
- busy  output  1  high when state is not IDLE or the FIFO is not empty
- op_cnt  output  CNT_W  count of results accepted by the consumer

Behaviour:
- Reset (synchronous, rst=1 at the edge):
  - FIFO flushed; pointers and count set to 0.
  - State goes to IDLE.
  - alu_a, alu_b, alu_ch, res_data, the res flags, the accumulator and op_cnt all go to 0; res_valid goes to 0.
  - Reset overrides every other event in the same cycle, including reset arriving mid-operation. In-flight and buffered commands are discarded and produce no result.
- FIFO:
  - Push on cmd_valid && cmd_ready.
  - cmd_ready = (count != DEPTH). It depends only on occupancy, so a pop in the same cycle does not allow a push when the FIFO is full.
  - A simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
  - Entries are {op, a, b, acc}.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: if the FIFO is not empty, pop the head, load alu_a/alu_b/alu_ch from it, and go to EXEC. Otherwise stay.
  - EXEC: lasts exactly one cycle, while the ALU settles.
    - At the closing edge: res_data <= alu_f, res_zero <= zero_f, res_over <= over_f, res_cout <= cout_f, accumulator <= alu_f, res_valid <= 1.
    - Go to DONE.
  - DONE: res_valid is high; res_data and the flags are held stable while res_ready=0.
    - On res_ready=1: op_cnt increments (wraps at 2^CNT_W) and res_valid <= 0.
    - If the FIFO is not empty in that same cycle, pop and load the ALU registers and go straight to EXEC. Otherwise go to IDLE.
- Latency: a command pushed at edge E0 into an empty, idle block is issued at E1 and has res_valid=1 after E2.
  - Back-to-back throughput is one result per 2 cycles with res_ready tied high.
- Ordering:
  - Results appear in strict command order.
  - Up to DEPTH+1 commands are outstanding (DEPTH in the FIFO plus one in EXEC/DONE).
- alu_a/alu_b/alu_ch keep their last issued values outside EXEC.
- The block does not interpret opcodes; every 3-bit value is forwarded.

Optional Feature:
- Macro ALU_SEQ_ACC_EN.
- Defined: when a popped entry has acc=1, alu_a is loaded from the accumulator instead of the entry's a. The accumulator value used is the one current at the pop edge, so it includes a result captured at an earlier edge.
- Undefined: cmd_acc is ignored and the accumulator register is still present (updated but unused). alu_a always equals the command's a.

Test Plan:
- Reset, then push op=000 a=3 b=5 with res_ready=1 -> res_valid two edges after accept; res_data=8, over=1, cout=0, zero=0; op_cnt=1.
- Push op=001 a=5 b=5 -> res_data=0, zero=1, cout=1, over=0.
- Hold res_ready=0 and push 7 commands back to back -> exactly DEPTH+1=5 accepted, cmd_ready=0 afterwards.
  - Then release res_ready -> 5 results in order; res_data stable throughout every stall cycle.
- Push op=011 a=0xC b=0xA, op=100 a=0x3 b=0x4, op=101 a=0xF b=0x1 -> results 0x8, 0x7, 0xE; alu_ch observed as 011, 100, 101.
- Push op=000 a=1 b=2, then op=000 acc=1 a=1 b=4 -> with ALU_SEQ_ACC_EN: 3 then 7; without it: 3 then 5.
- Assert rst for 1 cycle while in DONE with 2 FIFO entries -> after the edge: res_valid=0, cmd_ready=1, busy=0, op_cnt=0, accumulator=0.
  - No further results appear without new pushes.

Source files
------------

// File: rtl/alu_seq.sv
// Command sequencer in front of a 4-bit combinational ALU: FIFO-buffered commands, in-order issue, registered results.
// Optional ALU_SEQ_ACC_EN: a command with acc=1 takes operand a from the accumulator.
module alu_seq #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic             cmd_acc,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_ch,
  input  logic [3:0]       alu_f,
  input  logic             zero_f,
  input  logic             over_f,
  input  logic             cout_f,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_data,
  output logic             res_zero,
  output logic             res_over,
  output logic             res_cout,
  output logic             busy,
  output logic [CNT_W-1:0] op_cnt
);

  // Handshakes: a transfer happens on any rising edge where valid && ready.
  // cmd_ready depends only on occupancy; res_valid is held with stable data until res_ready.

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       acc;
  } entry_t;

  entry_t        fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  state_t        state;
  logic [3:0]    acc_q;
  entry_t        head;
  logic [3:0]    next_a;
  logic          push;
  logic          pop;
  logic          fifo_empty;

  assign fifo_empty = (count == '0);
  assign cmd_ready  = (count != FULL_CNT);
  assign push       = cmd_valid && cmd_ready;
  assign pop        = !fifo_empty && ((state == IDLE) || ((state == DONE) && res_ready));
  assign head       = fifo_mem[rd_ptr];
  assign busy       = (state != IDLE) || !fifo_empty;

`ifdef ALU_SEQ_ACC_EN
  assign next_a = head.acc ? acc_q : head.a;
`else
  // Accumulator still tracks results but never feeds the ALU in this build.
  logic unused_acc;
  assign next_a     = head.a;
  assign unused_acc = ^{head.acc, acc_q};
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{op: cmd_op, a: cmd_a, b: cmd_b, acc: cmd_acc};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ch    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_zero  <= 1'b0;
      res_over  <= 1'b0;
      res_cout  <= 1'b0;
      acc_q     <= '0;
      op_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            alu_a  <= next_a;
            alu_b  <= head.b;
            alu_ch <= head.op;
            state  <= EXEC;
          end
        end
        EXEC: begin
          res_data  <= alu_f;
          res_zero  <= zero_f;
          res_over  <= over_f;
          res_cout  <= cout_f;
          acc_q     <= alu_f;
          res_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            op_cnt    <= op_cnt + CNT_W'(1);
            res_valid <= 1'b0;
            // Chain straight into the next command to keep one result per two cycles.
            if (pop) begin
              alu_a  <= next_a;
              alu_b  <= head.b;
              alu_ch <= head.op;
              state  <= EXEC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: behavioural 4-bit ALU, command scoreboard, directed and random steps.
// Build with or without ALU_SEQ_ACC_EN; expectations follow the same macro.
module tb_alu_seq;

  localparam int W = 18;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic       cmd_acc;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_ch;
  logic [3:0] alu_f;
  logic       zero_f;
  logic       over_f;
  logic       cout_f;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic       res_zero;
  logic       res_over;
  logic       res_cout;
  logic       busy;
  logic [7:0] op_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // {op[17:15], a[14:11], b[10:7], f[6:3], zero[2], over[1], cout[0]}
  logic [W-1:0] exp_q[$];
  logic [3:0]   tb_acc;

  alu_seq #(.DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc(cmd_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ch(alu_ch),
    .alu_f(alu_f), .zero_f(zero_f), .over_f(over_f), .cout_f(cout_f),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_zero(res_zero), .res_over(res_over), .res_cout(res_cout),
    .busy(busy), .op_cnt(op_cnt)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference ALU: returns {f, zero, over, cout}.
  function automatic logic [6:0] alu_model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] f;
    logic       c;
    logic       v;
    s = '0;
    f = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'b000: begin
        s = {1'b0, a} + {1'b0, b};
        f = s[3:0];
        c = s[4];
        v = (a[3] == b[3]) && (f[3] != a[3]);
      end
      3'b001: begin
        s = {1'b0, a} + {1'b0, ~b} + 5'd1;
        f = s[3:0];
        c = s[4];
        v = (a[3] != b[3]) && (f[3] != a[3]);
      end
      3'b010:  f = ~a;
      3'b011:  f = a & b;
      3'b100:  f = a | b;
      3'b101:  f = a ^ b;
      3'b110:  f = {a[2:0], 1'b0};
      default: f = b;
    endcase
    return {f, (f == 4'd0), v, c};
  endfunction

  always_comb {alu_f, zero_f, over_f, cout_f} = alu_model(alu_ch, alu_a, alu_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver
  task automatic push_cmd(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic acc, output logic accepted);
    logic [3:0] ea;
    logic [6:0] r;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_acc   = acc;
    accepted  = cmd_ready;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (accepted) begin
      ea = a;
`ifdef ALU_SEQ_ACC_EN
      if (acc) ea = tb_acc;
`endif
      r      = alu_model(op, ea, b);
      tb_acc = r[6:3];
      exp_q.push_back({op, ea, b, r});
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || busy) && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 200) check("drain_timeout", exp_q.size(), 0);
  endtask

  // scoreboard monitor, sampling at the falling edge
  logic       stall_hold;
  logic [6:0] held;

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst) begin
      stall_hold = 1'b0;
    end else if (res_valid) begin
      if (stall_hold) check("stall_stable", {res_data, res_zero, res_over, res_cout}, held);
      if (res_ready) begin
        stall_hold = 1'b0;
        if (exp_q.size() == 0) begin
          check("spurious_result", res_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("res_data", res_data, e[6:3]);
          check("res_flags", {res_zero, res_over, res_cout}, e[2:0]);
          check("alu_ch", alu_ch, e[17:15]);
          check("alu_a", alu_a, e[14:11]);
          check("alu_b", alu_b, e[10:7]);
        end
      end else begin
        stall_hold = 1'b1;
        held       = {res_data, res_zero, res_over, res_cout};
      end
    end else begin
      stall_hold = 1'b0;
    end
  end

  initial begin
    logic ok;
    int   n_acc;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = '0;
    cmd_a      = '0;
    cmd_b      = '0;
    cmd_acc    = 1'b0;
    res_ready  = 1'b1;
    tb_acc     = '0;
    stall_hold = 1'b0;
    held       = '0;
    step(3);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_op_cnt", op_cnt, 8'd0);
    check("rst_alu_regs", {alu_a, alu_b, alu_ch}, 11'd0);
    check("rst_res_data", res_data, 4'd0);
    rst = 1'b0;
    step(1);

    // add 3+5: latency two edges after accept
    push_cmd(3'b000, 4'd3, 4'd5, 1'b0, ok);
    check("lat_e0_valid", res_valid, 1'b0);
    check("lat_e0_busy", busy, 1'b1);
    step(1);
    check("lat_e1_valid", res_valid, 1'b0);
    check("lat_e1_alu_ab", {alu_a, alu_b}, 8'h35);
    step(1);
    check("lat_e2_valid", res_valid, 1'b1);
    check("add_res", res_data, 4'h8);
    check("add_flags_zoc", {res_zero, res_over, res_cout}, 3'b010);
    step(1);
    check("op_cnt_1", op_cnt, 8'd1);
    check("valid_drop", res_valid, 1'b0);

    // sub 5-5
    push_cmd(3'b001, 4'd5, 4'd5, 1'b0, ok);
    step(2);
    check("sub_res", res_data, 4'h0);
    check("sub_flags_zoc", {res_zero, res_over, res_cout}, 3'b101);
    step(1);
    check("op_cnt_2", op_cnt, 8'd2);

    // stall: 7 attempted pushes, DEPTH+1 accepted
    res_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 7; i++) begin
      push_cmd(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, ok);
      if (ok) n_acc++;
    end
    check("stall_accepted", n_acc, 5);
    check("stall_cmd_ready", cmd_ready, 1'b0);
    check("stall_valid", res_valid, 1'b1);
    step(4);
    res_ready = 1'b1;
    wait_drain();
    check("op_cnt_7", op_cnt, 8'd7);

    // logic ops back to back
    push_cmd(3'b011, 4'hC, 4'hA, 1'b0, ok);
    push_cmd(3'b100, 4'h3, 4'h4, 1'b0, ok);
    push_cmd(3'b101, 4'hF, 4'h1, 1'b0, ok);
    wait_drain();
    check("xor_last_res", res_data, 4'hE);

    // accumulator chaining
    push_cmd(3'b000, 4'd1, 4'd2, 1'b0, ok);
    push_cmd(3'b000, 4'd1, 4'd4, 1'b1, ok);
    wait_drain();
`ifdef ALU_SEQ_ACC_EN
    check("acc_chain_res", res_data, 4'd7);
`else
    check("acc_chain_res", res_data, 4'd5);
`endif

    // random commands with random consumer back-pressure
    for (int i = 0; i < 24; i++) begin
      res_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0)
        push_cmd(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), ok);
      else
        step(1);
    end
    res_ready = 1'b1;
    wait_drain();

    // reset while in DONE with two commands buffered
    res_ready = 1'b0;
    push_cmd(3'b000, 4'd6, 4'd1, 1'b0, ok);
    push_cmd(3'b001, 4'd2, 4'd1, 1'b0, ok);
    push_cmd(3'b100, 4'd8, 4'd1, 1'b0, ok);
    check("pre_rst_valid", res_valid, 1'b1);
    rst = 1'b1;
    exp_q.delete();
    tb_acc = '0;
    step(1);
    rst = 1'b0;
    check("mid_rst_valid", res_valid, 1'b0);
    check("mid_rst_cmd_ready", cmd_ready, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_op_cnt", op_cnt, 8'd0);
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("post_rst_quiet", {res_valid, busy}, 2'b00);
    end

    // accumulator cleared by reset
    push_cmd(3'b000, 4'd5, 4'd0, 1'b1, ok);
    step(2);
`ifdef ALU_SEQ_ACC_EN
    check("acc_after_rst", res_data, 4'd0);
`else
    check("acc_after_rst", res_data, 4'd5);
`endif
    wait_drain();
    check("final_op_cnt", op_cnt, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
